// File: rtl/pe_tile_sequencer.sv
// PE tile sequencer: accepts a tile command, then for each weight pass loads
// the weight pad, pulses a PE start, walks the tile columns (stalling while
// the input pad is empty) and drains the psum pad. An abort in any busy state
// pulses the PE reset low and drops straight back to idle.
module pe_tile_sequencer #(
  parameter int TW_DW = 7,
  parameter int NP_DW = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [TW_DW-1:0] i_cfg_tw,
  input  logic [NP_DW-1:0] i_cfg_np,
  input  logic             i_tile_rdy,
  output logic             o_tile_ack,
  output logic             o_wload_rdy,
  input  logic             i_wload_ack,
  output logic             o_drain_rdy,
  input  logic             i_drain_ack,
  output logic             o_inst_start,
  output logic             o_inst_stall,
  output logic             o_inst_resetn,
  input  logic             i_in_valid,
  input  logic             i_col_done,
  input  logic             i_abort,
  output logic [TW_DW-1:0] o_col_idx,
  output logic [NP_DW-1:0] o_pass_idx,
  output logic             o_busy,
  output logic             o_tile_done,
  output logic             o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_START, S_RUN, S_STALL, S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [TW_DW-1:0] tw_q, tw_d, col_q, col_d;
  logic [NP_DW-1:0] np_q, np_d, pass_q, pass_d;
  logic             done_q, done_d;

  logic accept, cfg_bad, abort, last_col, last_pass;

  assign accept    = (state_q == S_IDLE) && i_tile_rdy;
  assign cfg_bad   = (i_cfg_tw == '0) || (i_cfg_np == '0);
  assign abort     = (state_q != S_IDLE) && i_abort;
  assign last_col  = (col_q == tw_q - TW_DW'(1));
  assign last_pass = (pass_q == np_q - NP_DW'(1));

  // State, counters, latched config and the done pulse register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      tw_q    <= '0;
      np_q    <= '0;
      col_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tw_q    <= tw_d;
      np_q    <= np_d;
      col_q   <= col_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter updates; abort wins over everything else.
  always_comb begin
    state_d = state_q;
    tw_d    = tw_q;
    np_d    = np_q;
    col_d   = col_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_tile_rdy) begin
            tw_d = i_cfg_tw;
            np_d = i_cfg_np;
            if (!cfg_bad) begin
              pass_d  = '0;
              state_d = S_WLOAD;
            end
          end
        end
        S_WLOAD: if (i_wload_ack) state_d = S_START;
        S_START: begin
          col_d   = '0;
          state_d = S_RUN;
        end
        S_RUN, S_STALL: begin
          // Finishing the last column beats an empty input pad.
          if (i_col_done && last_col) begin
            state_d = S_DRAIN;
          end else begin
            if (i_col_done) col_d = col_q + TW_DW'(1);
            state_d = i_in_valid ? S_RUN : S_STALL;
          end
        end
        S_DRAIN: begin
          if (i_drain_ack) begin
            if (last_pass) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              pass_d  = pass_q + NP_DW'(1);
              state_d = S_WLOAD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake acks are decoded from inputs; gated by reset so a held
  // tile request is not acknowledged while the block is in reset.
  assign o_tile_ack    = i_rstn && accept;
  assign o_err         = i_rstn && accept && cfg_bad;
  assign o_inst_resetn = ~abort;
  assign o_wload_rdy   = (state_q == S_WLOAD);
  assign o_drain_rdy   = (state_q == S_DRAIN);
  assign o_inst_start  = (state_q == S_START);
  assign o_inst_stall  = (state_q == S_STALL);
  assign o_busy        = (state_q != S_IDLE);
  assign o_col_idx     = col_q;
  assign o_pass_idx    = pass_q;
  assign o_tile_done   = done_q;

endmodule
